// File: rtl/decode_stage.sv
// decode_stage: one-deep registered instruction decoder with RUN/HALT FSM.
// Optional DECODE_STATS_EN adds instr_count_o, a count of accepted legal words.
module decode_stage #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          instr_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic                 flush_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic [4:0]           ra_o,
  output logic [4:0]           rb_o,
  output logic [4:0]           rd_o,
  output logic [3:0]           opcode_o,
  output logic [DATAWIDTH-1:0] imm_o,
  output logic [4:0]           wb_addr_o,
  output logic                 reg_we_o,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic                 branch_o,
  output logic                 jump_o,
  output logic                 illegal_o,
  output logic                 halted_o
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]          instr_count_o
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0]           ra;
    logic [4:0]           rb;
    logic [4:0]           rd;
    logic [3:0]           opcode;
    logic [DATAWIDTH-1:0] imm;
    logic [4:0]           wb_addr;
    logic                 reg_we;
    logic                 mem_rd;
    logic                 mem_wr;
    logic                 branch;
    logic                 jump;
    logic                 illegal;
  } dec_t;

  state_t state_q;
  logic   valid_q;
  logic   halted_q;
  dec_t   out_q;
  dec_t   dec;
  logic   accept;

  logic [12:0] off;
  logic [3:0]  op;
  logic        is_alu;
  logic        is_lw;
  logic        is_sw;
  logic        is_br;
  logic        is_jmp;
  logic        is_li;
  logic        is_ill;

  assign off = instr_i[31:19];
  assign op  = instr_i[3:0];

  assign instr_ready_o = (!valid_q || dec_ready_i)
                       && (state_q == RUN)
                       && !flush_i;

  assign accept = instr_valid_i && instr_ready_o;

  // Classify the incoming opcode into one-hot instruction classes
  always_comb begin
    is_alu = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    is_br  = 1'b0;
    is_jmp = 1'b0;
    is_li  = 1'b0;
    is_ill = 1'b0;
    case (op)
      4'd0, 4'd3, 4'd4, 4'd5,
      4'd6, 4'd7, 4'd8:        is_alu = 1'b1;
      4'd1:                    is_lw  = 1'b1;
      4'd2:                    is_sw  = 1'b1;
      4'd9, 4'd10, 4'd11:      is_br  = 1'b1;
      4'd12:                   is_jmp = 1'b1;
      4'd13:                   is_li  = 1'b1;
      default:                 is_ill = 1'b1;
    endcase
  end

  // Build the decoded bundle; wb_addr stays 0 unless a register is written
  always_comb begin
    dec        = '0;
    dec.ra     = instr_i[18:14];
    dec.rb     = instr_i[13:9];
    dec.rd     = instr_i[8:4];
    dec.opcode = op;
    dec.imm    = {{(DATAWIDTH-13){off[12]}}, off};
    unique case (1'b1)
      is_alu: begin
        dec.reg_we  = 1'b1;
        dec.wb_addr = instr_i[8:4];
      end
      is_lw: begin
        dec.mem_rd  = 1'b1;
        dec.reg_we  = 1'b1;
        dec.wb_addr = instr_i[13:9];
      end
      is_sw:  dec.mem_wr = 1'b1;
      is_br:  dec.branch = 1'b1;
      is_jmp: dec.jump   = 1'b1;
      is_li: begin
        dec.reg_we  = 1'b1;
        dec.wb_addr = instr_i[8:4];
      end
      is_ill: dec.illegal = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  // Output register and RUN/HALT FSM; flush beats acceptance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      out_q    <= '0;
    end else if (flush_i) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      out_q    <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      out_q   <= dec;
      if (dec.illegal) begin
        state_q  <= HALT;
        halted_q <= 1'b1;
      end
    end else if (valid_q && dec_ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef DECODE_STATS_EN
  logic [31:0] cnt_q;

  // Count legal accepted words; wraps naturally at 32 bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (accept && !dec.illegal) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign instr_count_o = cnt_q;
`endif

  assign dec_valid_o = valid_q;
  assign ra_o        = out_q.ra;
  assign rb_o        = out_q.rb;
  assign rd_o        = out_q.rd;
  assign opcode_o    = out_q.opcode;
  assign imm_o       = out_q.imm;
  assign wb_addr_o   = out_q.wb_addr;
  assign reg_we_o    = out_q.reg_we;
  assign mem_rd_o    = out_q.mem_rd;
  assign mem_wr_o    = out_q.mem_wr;
  assign branch_o    = out_q.branch;
  assign jump_o      = out_q.jump;
  assign illegal_o   = out_q.illegal;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage.
// Exercises decode, stall, HALT, flush and reset behaviour.
module tb_decode_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          flush;
  logic          dec_valid;
  logic          dec_ready;
  logic [4:0]    ra, rb, rd;
  logic [3:0]    opcode;
  logic [DW-1:0] imm;
  logic [4:0]    wb_addr;
  logic          reg_we, mem_rd, mem_wr;
  logic          branch, jump, illegal, halted;
`ifdef DECODE_STATS_EN
  logic [31:0]   instr_count;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.DATAWIDTH(DW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_i       (instr),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready),
    .flush_i       (flush),
    .dec_valid_o   (dec_valid),
    .dec_ready_i   (dec_ready),
    .ra_o          (ra),
    .rb_o          (rb),
    .rd_o          (rd),
    .opcode_o      (opcode),
    .imm_o         (imm),
    .wb_addr_o     (wb_addr),
    .reg_we_o      (reg_we),
    .mem_rd_o      (mem_rd),
    .mem_wr_o      (mem_wr),
    .branch_o      (branch),
    .jump_o        (jump),
    .illegal_o     (illegal),
    .halted_o      (halted)
`ifdef DECODE_STATS_EN
    ,
    .instr_count_o (instr_count)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w,
                       input logic rdy, input logic fl);
    instr_valid = v;
    instr       = w;
    dec_ready   = rdy;
    flush       = fl;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_valid", dec_valid, 0);
    check("rst_halt", halted, 0);
    check("rst_we", reg_we, 0);
    check("rst_wb", wb_addr, 0);
    check("rst_ill", illegal, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", instr_ready, 1);

    drive(1'b1, 32'h0000_4230, 1'b1, 1'b0);
    tick();
    check("add_valid", dec_valid, 1);
    check("add_we", reg_we, 1);
    check("add_wb", wb_addr, 3);
    check("add_ra", ra, 1);
    check("add_rb", rb, 1);

    drive(1'b1, 32'hFFF8_0801, 1'b1, 1'b0);
    tick();
    check("lw_imm", imm, 64'hFFFF_FFFF);
    check("lw_mrd", mem_rd, 1);
    check("lw_we", reg_we, 1);
    check("lw_wb", wb_addr, 4);

    drive(1'b1, 32'h0D21_0809, 1'b1, 1'b0);
    tick();
    check("beq_br", branch, 1);
    check("beq_imm", imm, 420);
    check("beq_we", reg_we, 0);
    check("beq_wb", wb_addr, 0);

    drive(1'b1, 32'h0000_CA92, 1'b1, 1'b0);
    tick();
    check("sw_mwr", mem_wr, 1);
    check("sw_we", reg_we, 0);
    check("sw_wb", wb_addr, 0);
    check("sw_mrd", mem_rd, 0);

    drive(1'b1, 32'h8000_000C, 1'b1, 1'b0);
    tick();
    check("jmp_j", jump, 1);
    check("jmp_imm", imm, 64'hFFFF_F000);
    check("jmp_br", branch, 0);

    drive(1'b1, 32'h7FF8_01FD, 1'b1, 1'b0);
    tick();
    check("li_we", reg_we, 1);
    check("li_wb", wb_addr, 31);
    check("li_imm", imm, 64'h0000_0FFF);
    check("li_jmp", jump, 0);

    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("idle_valid", dec_valid, 0);

    // back-to-back with a 2-cycle stall
    drive(1'b1, 32'h0000_0050, 1'b1, 1'b0);
    tick();
    check("w1_wb", wb_addr, 5);
    drive(1'b1, 32'h0000_0060, 1'b0, 1'b0);
    check("stall_rdy0", instr_ready, 0);
    tick();
    check("stall1_wb", wb_addr, 5);
    check("stall1_v", dec_valid, 1);
    check("stall_rdy1", instr_ready, 0);
    tick();
    check("stall2_wb", wb_addr, 5);
    drive(1'b1, 32'h0000_0060, 1'b1, 1'b0);
    check("unstall_rdy", instr_ready, 1);
    tick();
    check("w2_wb", wb_addr, 6);
    drive(1'b1, 32'h0000_0070, 1'b1, 1'b0);
    tick();
    check("w3_wb", wb_addr, 7);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("drain_v", dec_valid, 0);

    // illegal opcode, HALT, flush
    drive(1'b1, 32'h0000_000E, 1'b0, 1'b0);
    tick();
    check("ill_flag", illegal, 1);
    check("ill_halt", halted, 1);
    check("ill_v", dec_valid, 1);
    drive(1'b1, 32'h0000_4230, 1'b1, 1'b0);
    check("halt_rdy", instr_ready, 0);
    tick();
    check("halt_keep", illegal, 1);
    check("halt_drop", reg_we, 0);
    check("halt_cons", dec_valid, 0);
    drive(1'b1, 32'h0000_4230, 1'b1, 1'b1);
    check("flush_rdy", instr_ready, 0);
    tick();
    check("flush_v", dec_valid, 0);
    check("flush_run", halted, 0);
    drive(1'b1, 32'h0000_4230, 1'b1, 1'b0);
    check("run_rdy", instr_ready, 1);
    tick();
    check("post_v", dec_valid, 1);
    check("post_wb", wb_addr, 3);

    // flush beats a coinciding accept
    drive(1'b1, 32'h0000_0050, 1'b1, 1'b1);
    tick();
    check("fl_win_v", dec_valid, 0);

    // opcode 15 is illegal too; reset from HALT
    drive(1'b1, 32'h0000_000F, 1'b0, 1'b0);
    tick();
    check("op15_ill", illegal, 1);
    check("op15_we", reg_we, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("rh_halt", halted, 0);
    check("rh_ill", illegal, 0);
    check("rh_v", dec_valid, 0);
    rst = 1'b0;

    // reset mid-stall
    drive(1'b1, 32'h0000_4230, 1'b0, 1'b0);
    tick();
    check("ms_v", dec_valid, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("ms_v0", dec_valid, 0);
    check("ms_we", reg_we, 0);
    check("ms_wb", wb_addr, 0);
    check("ms_ra", ra, 0);
    rst = 1'b0;
    #1;
    check("ms_rdy", instr_ready, 1);

`ifdef DECODE_STATS_EN
    check("cnt_rst", instr_count, 0);
    dut.cnt_q = 32'hFFFF_FFFF;
    drive(1'b1, 32'h0000_4230, 1'b1, 1'b0);
    tick();
    check("cnt_wrap", instr_count, 0);
    drive(1'b1, 32'h0000_000E, 1'b1, 1'b0);
    tick();
    check("cnt_ill", instr_count, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 32, giving the width of imm_o; the legal range is 16 to 64.
REQ-002 Port clk_i SHALL be an input, 1 bit wide, and is the single clock; all logic is rising-edge.
REQ-003 Port rst_i SHALL be an input, 1 bit wide; it is the reset, synchronous and active-high.
REQ-004 Port instr_i SHALL be an input, 32 bits wide, carrying the instruction word: offset[31:19], ra[18:14], rb[13:9], rd[8:4], opcode[3:0].
REQ-005 Port instr_valid_i SHALL be an input, 1 bit wide, indicating that instr_i holds a valid word.
REQ-006 Port instr_ready_o SHALL be an output, 1 bit wide, indicating that the block accepts a word this cycle.
REQ-007 Port flush_i SHALL be an input, 1 bit wide, requesting that the output register be discarded and HALT be left.
REQ-008 Port dec_valid_o SHALL be an output, 1 bit wide, indicating that the decoded outputs are valid.
REQ-009 Port dec_ready_i SHALL be an input, 1 bit wide, indicating that the downstream stage consumes the decoded outputs.
REQ-010 Ports ra_o, rb_o and rd_o SHALL be outputs, 5 bits wide each, carrying the raw register fields.
REQ-011 Port opcode_o SHALL be an output, 4 bits wide, carrying the raw opcode.
REQ-012 Port imm_o SHALL be an output, DATAWIDTH bits wide, carrying the offset sign-extended from bit 12.
REQ-013 Port wb_addr_o SHALL be an output, 5 bits wide, carrying the writeback register address.
REQ-014 Port reg_we_o SHALL be an output, 1 bit wide, enabling the register write.
REQ-015 Ports mem_rd_o, mem_wr_o, branch_o and jump_o SHALL be outputs, 1 bit wide each, flagging the instruction class.
REQ-016 Port illegal_o SHALL be an output, 1 bit wide, flagging an illegal opcode.
REQ-017 Port halted_o SHALL be an output, 1 bit wide, high while the FSM is in HALT.

Function
REQ-018 A word SHALL be accepted on a cycle where instr_valid_i and instr_ready_o are both 1; the decoded result appears registered on the next edge, giving 1-cycle latency.
REQ-019 instr_ready_o SHALL equal (!dec_valid_o || dec_ready_i) && state==RUN && !flush_i, so the block sustains full throughput with no bubbles.
REQ-020 While dec_valid_o is 1 and dec_ready_i is 0, all decoded outputs SHALL hold stable.
REQ-021 Opcode decode SHALL be as follows:
- 0,3,4,5,6,7,8 (ADD, SUB, MUL, DIV, AND, OR, XOR): reg_we=1, wb_addr=rd.
- 1 (LW): mem_rd=1, reg_we=1, wb_addr=rb, base ra.
- 2 (SW): mem_wr=1, base ra, data rb.
- 9, 10, 11 (BEQ, BGT, BGE): branch=1.
- 12 (JMP): jump=1.
- 13 (LI): reg_we=1, wb_addr=rd, value imm_o.
- 14, 15: illegal=1, all other flags 0.
REQ-022 Any flag not named for an opcode in REQ-021 SHALL be 0.
REQ-023 wb_addr_o SHALL be 0 whenever reg_we_o is 0.
REQ-024 The FSM SHALL have two states, RUN and HALT.
REQ-025 Acceptance of an illegal opcode in RUN SHALL present it with illegal_o=1 and move the FSM to HALT on the same edge.
REQ-026 In HALT, instr_ready_o SHALL be 0; the pending illegal result remains valid until it is consumed.
REQ-027 flush_i=1 SHALL, on the next edge, clear dec_valid_o to 0 and set the state to RUN; no word is accepted on a flush cycle.
REQ-028 If flush_i, an acceptance condition and dec_ready_i coincide, flush SHALL win and the word is dropped.

Reset
REQ-029 When rst_i=1 at an edge, the block SHALL set state to RUN and dec_valid_o to 0, and every decoded output, illegal_o and halted_o to 0.
REQ-030 A reset mid-stall or in HALT SHALL discard the held word, and instr_ready_o SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-031 With DECODE_STATS_EN defined, the block SHALL add output instr_count_o (32 bits) counting accepted legal words; the counter resets to 0, wraps from 0xFFFFFFFF to 0, and is not advanced by illegal, dropped or flushed words.
REQ-032 Without DECODE_STATS_EN, the port and counter SHALL be absent and the behaviour otherwise SHALL be identical.

Verification
REQ-033 Drive 0x00004230 (ADD ra=1 rb=1 rd=3) -> next cycle: dec_valid=1, reg_we=1, wb_addr=3, ra=1, rb=1.
REQ-034 Drive 0xFFF80801 (LW off=-1 ra=0 rb=4) -> imm_o=0xFFFFFFFF, mem_rd=1, reg_we=1, wb_addr=4.
REQ-035 Drive 0x0D210809 (BEQ off=420 ra=4 rb=4) -> branch=1, imm_o=420, reg_we=0, wb_addr=0.
REQ-036 Send 3 back-to-back words with dec_ready_i=0 for 2 cycles -> word 1 held stable, instr_ready_o=0, all 3 words delivered in order with none lost.
REQ-037 Drive 0x0000000E, then a valid ADD -> illegal_o=1, halted_o=1, ADD not accepted; pulse flush_i -> dec_valid_o=0, RUN, ADD accepted next cycle.
REQ-038 With DECODE_STATS_EN, preload the counter to 0xFFFFFFFF and accept 1 legal word -> instr_count_o=0; assert rst_i mid-stall -> all outputs 0 next cycle.
